// File: rtl/channel_tx.sv
// Flit-channel transmitter: copies packets from an upstream buffer into a two-slot
// ping-pong store and replays them on a 4-phase req/ack channel.
//   state   | meaning
//   F_IDLE  | waiting for sw_req with a free write slot
//   F_COPY  | grant high, one flit copied per cycle
//   F_REL   | copy done, waiting for sw_req to drop
//   S_IDLE  | waiting for a full read slot
//   S_REQ   | ch_req high, waiting for ch_ack
//   S_ACKLO | ch_req low, waiting for ch_ack to drop
module channel_tx #(
  parameter int FLITS     = 8,
  parameter int SIZE      = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sw_req,
  output logic                 sw_gnt,
  output logic [ADDR_BITS-1:0] buf_addr,
  input  logic [SIZE-1:0]      buf_data,
  output logic                 ch_req,
  output logic [SIZE-1:0]      ch_flit,
  input  logic                 ch_ack,
  output logic                 busy,
  output logic [15:0]          pkt_count,
  output logic                 proto_err
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(FLITS - 1);

  typedef enum logic [1:0] {F_IDLE, F_COPY, F_REL} fstate_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKLO} sstate_e;

  fstate_e              f_q, f_d;
  sstate_e              s_q, s_d;
  logic [1:0]           full_q, full_d;
  logic                 wp_q, wp_d, rp_q, rp_d;
  logic                 gnt_q, gnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, idx_q, idx_d, idx_inc;
  logic                 req_q, req_d;
  logic [SIZE-1:0]      flit_q, flit_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [SIZE-1:0]      slot_q [2][2**ADDR_BITS];
  logic                 fetch_start, copy_done, send_start, send_done, flit_next;

  assign fetch_start = (f_q == F_IDLE) && sw_req && !full_q[wp_q];
  assign copy_done   = (f_q == F_COPY) && (addr_q == LAST);
  assign send_start  = (s_q == S_IDLE) && full_q[rp_q];
  assign send_done   = (s_q == S_ACKLO) && !ch_ack && (idx_q == LAST);
  assign flit_next   = (s_q == S_ACKLO) && !ch_ack && (idx_q != LAST);
  assign idx_inc     = idx_q + ADDR_BITS'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_q    <= F_IDLE;
      s_q    <= S_IDLE;
      full_q <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      gnt_q  <= 1'b0;
      addr_q <= '0;
      idx_q  <= '0;
      req_q  <= 1'b0;
      flit_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      f_q    <= f_d;
      s_q    <= s_d;
      full_q <= full_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      gnt_q  <= gnt_d;
      addr_q <= addr_d;
      idx_q  <= idx_d;
      req_q  <= req_d;
      flit_q <= flit_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Slot contents need no reset; full_q qualifies them.
  always_ff @(posedge clk) begin
    if (f_q == F_COPY) slot_q[wp_q][addr_q] <= buf_data;
  end

  always_comb begin
    f_d = f_q;
    case (f_q)
      F_IDLE:  if (fetch_start) f_d = F_COPY;
      F_COPY:  if (copy_done) f_d = F_REL;
      F_REL:   if (!sw_req) f_d = F_IDLE;
      default: f_d = F_IDLE;
    endcase
  end

  always_comb begin
    s_d = s_q;
    case (s_q)
      S_IDLE:  if (send_start) s_d = S_REQ;
      S_REQ:   if (ch_ack) s_d = S_ACKLO;
      S_ACKLO: if (!ch_ack) s_d = (idx_q == LAST) ? S_IDLE : S_REQ;
      default: s_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = gnt_q;
    addr_d = addr_q;
    full_d = full_q;
    idx_d  = idx_q;
    req_d  = req_q;
    flit_d = flit_q;
    wp_d   = wp_q ^ copy_done;
    rp_d   = rp_q ^ send_done;
    cnt_d  = cnt_q + 16'(send_done);
    err_d  = err_q | ((s_q == S_IDLE) && ch_ack);
    if (fetch_start) begin
      gnt_d  = 1'b1;
      addr_d = '0;
    end else if (f_q == F_COPY) begin
      addr_d = copy_done ? '0 : addr_q + ADDR_BITS'(1);
      if (copy_done) gnt_d = 1'b0;
    end
    // Fetch and send never touch the same slot on one edge: wp targets an empty slot, rp a full one.
    if (copy_done) full_d[wp_q] = 1'b1;
    if (send_done) full_d[rp_q] = 1'b0;
    if (send_start) begin
      req_d  = 1'b1;
      idx_d  = '0;
      flit_d = slot_q[rp_q][0];
    end else if (flit_next) begin
      req_d  = 1'b1;
      idx_d  = idx_inc;
      flit_d = slot_q[rp_q][idx_inc];
    end else if ((s_q == S_REQ) && ch_ack) begin
      req_d = 1'b0;
    end
  end

  assign sw_gnt    = gnt_q;
  assign buf_addr  = addr_q;
  assign ch_req    = req_q;
  assign ch_flit   = flit_q;
  assign pkt_count = cnt_q;
  assign proto_err = err_q;
  assign busy      = (|full_q) || (f_q != F_IDLE) || (s_q != S_IDLE);

endmodule

// File: tb/tb_channel_tx.sv
// Bench for channel_tx: upstream buffer and downstream rx models around an 8-flit
// instance, plus a 2-flit instance; flits are checked against a scoreboard queue.
module tb_channel_tx;

  logic        clk;
  logic        rst_n;
  logic        sw_req, sw_gnt, ch_req, ch_ack, busy, proto_err;
  logic [2:0]  buf_addr;
  logic [7:0]  buf_data, ch_flit;
  logic [15:0] pkt_count;
  logic [7:0]  up_mem [8];
  logic        rx_ack, rx_hold, spur_ack;
  logic [7:0]  sb_q [$];

  logic        sw_req2, sw_gnt2, ch_req2, ch_ack2, busy2, proto_err2;
  logic [0:0]  buf_addr2;
  logic [7:0]  buf_data2, ch_flit2;
  logic [15:0] pkt_count2;
  logic [7:0]  sb2_q [$];
  int          rx2_n;

  int n_tests = 0;
  int n_fail  = 0;

  assign buf_data  = up_mem[buf_addr];
  assign ch_ack    = rx_ack | spur_ack;
  assign buf_data2 = (buf_addr2 == 1'b1) ? 8'h5A : 8'hA5;

  channel_tx #(.FLITS(8), .SIZE(8), .ADDR_BITS(3)) u_dut (
    .clk(clk), .reset(rst_n), .sw_req(sw_req), .sw_gnt(sw_gnt), .buf_addr(buf_addr),
    .buf_data(buf_data), .ch_req(ch_req), .ch_flit(ch_flit), .ch_ack(ch_ack),
    .busy(busy), .pkt_count(pkt_count), .proto_err(proto_err)
  );

  channel_tx #(.FLITS(2), .SIZE(8), .ADDR_BITS(1)) u_dut2 (
    .clk(clk), .reset(rst_n), .sw_req(sw_req2), .sw_gnt(sw_gnt2), .buf_addr(buf_addr2),
    .buf_data(buf_data2), .ch_req(ch_req2), .ch_flit(ch_flit2), .ch_ack(ch_ack2),
    .busy(busy2), .pkt_count(pkt_count2), .proto_err(proto_err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Downstream rx for the 8-flit instance: pops the scoreboard on each ch_req rise.
  initial begin
    int         st;
    int         cnt;
    logic [7:0] exp;
    st = 0; cnt = 0; rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0; rx_ack = 1'b0;
      end else begin
        case (st)
          0: if (ch_req) begin
               if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
               else begin
                 exp = sb_q.pop_front();
                 chk("flit", 32'(ch_flit), 32'(exp));
               end
               cnt = 1; st = 1;
             end
          1: if (!rx_hold) begin
               if (cnt == 0) begin rx_ack = 1'b1; st = 2; end
               else cnt--;
             end
          default: if (!ch_req) begin rx_ack = 1'b0; st = 0; end
        endcase
      end
    end
  end

  // Downstream rx for the 2-flit instance, acking on the next cycle.
  initial begin
    int         st;
    logic [7:0] exp;
    st = 0; ch_ack2 = 1'b0; rx2_n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st = 0; ch_ack2 = 1'b0;
      end else if (st == 0) begin
        if (ch_req2) begin
          if (rx2_n % 2 == 0) chk("rp2", 32'(u_dut2.rp_q), 32'((rx2_n / 2) % 2));
          if (sb2_q.size() == 0) chk("sb2_underflow", 32'(sb2_q.size()), 32'd1);
          else begin
            exp = sb2_q.pop_front();
            chk("flit2", 32'(ch_flit2), 32'(exp));
          end
          rx2_n++;
          ch_ack2 = 1'b1; st = 1;
        end
      end else if (!ch_req2) begin
        ch_ack2 = 1'b0; st = 0;
      end
    end
  end

  task automatic fetch_pkt(input logic [7:0] base, input int max_wait, output int lat);
    for (int i = 0; i < 8; i++) begin
      up_mem[i] = base + 8'(i);
      sb_q.push_back(base + 8'(i));
    end
    sw_req = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!sw_gnt && lat < max_wait) begin
      @(negedge clk);
      lat++;
    end
    if (!sw_gnt) chk("gnt_timeout", 32'(sw_gnt), 32'd1);
    else begin
      for (int i = 0; i < 8; i++) begin
        chk("gnt_hi", 32'(sw_gnt), 32'd1);
        chk("buf_addr", 32'(buf_addr), 32'(i));
        @(negedge clk);
      end
      chk("gnt_lo", 32'(sw_gnt), 32'd0);
    end
    sw_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cnt(input logic [15:0] n, input int budget);
    int w;
    w = 0;
    while (pkt_count != n && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("pkt_count", 32'(pkt_count), 32'(n));
  endtask

  initial begin
    int lat;
    int w;
    int hits;
    rst_n = 1'b1; sw_req = 1'b0; sw_req2 = 1'b0; rx_hold = 1'b0; spur_ack = 1'b0;
    for (int i = 0; i < 8; i++) up_mem[i] = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(sw_gnt), 32'd0);
    chk("rst_req", 32'(ch_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(pkt_count), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single packet 0x10..0x17
    fetch_pkt(8'h10, 20, lat);
    chk("gnt_lat", 32'(lat), 32'd1);
    wait_cnt(16'd1, 200);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sb_left1", 32'(sb_q.size()), 32'd0);

    // Three back-to-back requests with the channel stalled
    rx_hold = 1'b1;
    fetch_pkt(8'h20, 20, lat);
    chk("gnt_lat_p1", 32'(lat), 32'd1);
    fetch_pkt(8'h30, 20, lat);
    chk("gnt_lat_p2", 32'(lat), 32'd1);
    fork
      fetch_pkt(8'h40, 400, lat);
      begin
        repeat (20) @(negedge clk);
        chk("gnt_both_full", 32'(sw_gnt), 32'd0);
        chk("busy_full", 32'(busy), 32'd1);
        rx_hold = 1'b0;
        wait_cnt(16'd2, 200);
        chk("gnt_same_edge", 32'(sw_gnt), 32'd0);
        @(negedge clk);
        chk("gnt_after_free", 32'(sw_gnt), 32'd1);
      end
    join
    wait_cnt(16'd4, 400);
    chk("sb_left2", 32'(sb_q.size()), 32'd0);

    // Ack stall for 50 cycles on flit 0
    rx_hold = 1'b1;
    fetch_pkt(8'h50, 20, lat);
    w = 0;
    while (!ch_req && w < 20) begin @(negedge clk); w++; end
    for (int i = 0; i < 50; i++) begin
      chk("stall_req", 32'(ch_req), 32'd1);
      chk("stall_flit", 32'(ch_flit), 32'h50);
      @(negedge clk);
    end
    rx_hold = 1'b0;
    wait_cnt(16'd5, 200);

    // Reset while flit 3 is on the channel
    fetch_pkt(8'h60, 20, lat);
    w = 0;
    while (!(ch_req && ch_flit == 8'h63) && w < 100) begin @(negedge clk); w++; end
    chk("flit3_seen", 32'(ch_flit), 32'h63);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(ch_req), 32'd0);
    chk("mid_rst_flit", 32'(ch_flit), 32'd0);
    chk("mid_rst_gnt", 32'(sw_gnt), 32'd0);
    chk("mid_rst_addr", 32'(buf_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(pkt_count), 32'd0);
    chk("mid_rst_err", 32'(proto_err), 32'd0);
    repeat (3) @(negedge clk);
    sb_q.delete();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ch_req) hits++;
    end
    chk("no_req_after_rst", 32'(hits), 32'd0);
    chk("cnt_after_rst", 32'(pkt_count), 32'd0);

    // Spurious ack while idle
    chk("err_clear", 32'(proto_err), 32'd0);
    spur_ack = 1'b1;
    @(negedge clk);
    chk("err_set", 32'(proto_err), 32'd1);
    spur_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(proto_err), 32'd1);
    fetch_pkt(8'h70, 20, lat);
    wait_cnt(16'd1, 200);
    chk("sb_left3", 32'(sb_q.size()), 32'd0);
    chk("err_held", 32'(proto_err), 32'd1);

    // Two-flit instance: four packets of {A5,5A}
    for (int k = 0; k < 4; k++) begin
      chk("wp2", 32'(u_dut2.wp_q), 32'(k % 2));
      sb2_q.push_back(8'hA5);
      sb2_q.push_back(8'h5A);
      sw_req2 = 1'b1;
      w = 0;
      while (!sw_gnt2 && w < 100) begin @(negedge clk); w++; end
      hits = 0;
      while (sw_gnt2 && hits < 10) begin @(negedge clk); hits++; end
      chk("gnt2_len", 32'(hits), 32'd2);
      sw_req2 = 1'b0;
      @(negedge clk);
    end
    w = 0;
    while (pkt_count2 != 16'd4 && w < 200) begin @(negedge clk); w++; end
    chk("pkt_count2", 32'(pkt_count2), 32'd4);
    chk("flits2", 32'(rx2_n), 32'd8);
    chk("sb2_left", 32'(sb2_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
